// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame geometry and the
// default bit period for a 100 MHz clock at 9600 baud.
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int UART_CNT_W           = 19;
  localparam int UART_BIT_CNT_DEFAULT = 10416;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer for the UART receiver. Counts up to a programmable
// target and emits a one-cycle sample tick on the match cycle, then restarts.
module rx_bit_timer
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [UART_CNT_W-1:0] target,
  output logic                  tick
);

  logic [UART_CNT_W-1:0] cnt;

  assign tick = (cnt == target);

  // Counter restarts on clear or on reaching the target, so it never wraps past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART 8N1 receiver. Synchronises rx, detects the start edge, samples each
// bit at mid-period and delivers the byte with a one-cycle valid strobe, or
// a one-cycle frame_err strobe when the stop bit is sampled low.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int BIT_CNT = UART_BIT_CNT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      valid,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int IDX_W    = $clog2(UART_DATA_BITS);
  localparam logic [UART_CNT_W-1:0] BIT_TGT  = UART_CNT_W'(BIT_CNT - 1);
  localparam logic [UART_CNT_W-1:0] HALF_TGT = UART_CNT_W'(HALF_CNT - 1);
  localparam logic [IDX_W-1:0]      BIT_LAST = IDX_W'(UART_DATA_BITS - 1);

  rx_state_t                 state, state_nx;
  logic                      rx_meta, rx_s, rx_prev;
  logic [1:0]                prime;
  logic                      armed;
  logic                      fall;
  logic                      clear, tick;
  logic [UART_CNT_W-1:0]     target;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      shift_en, load_byte, flag_err;

  // Two-flop synchroniser plus previous-sample flop for edge detection.
  // The synchroniser resets to 1, so start detection is armed only once a
  // genuine post-reset high has passed through; a line held low across
  // reset release is therefore never mistaken for a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      prime   <= 2'b00;
      armed   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      prime   <= {prime[0], 1'b1};
      if (prime[1] && rx_s) begin
        armed <= 1'b1;
      end
    end
  end

  assign fall = armed & rx_prev & ~rx_s;

  // Counter restarts on every state entry and is held at zero while idle.
  assign clear = (state == S_IDLE) || (state_nx != state);

  rx_bit_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .target (target),
    .tick   (tick)
  );

  // State register; busy is registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != S_IDLE);
    end
  end

  // Next-state logic, sample-point target selection and datapath enables.
  always_comb begin
    state_nx  = state;
    target    = BIT_TGT;
    shift_en  = 1'b0;
    load_byte = 1'b0;
    flag_err  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall) begin
          state_nx = S_START;
        end
      end
      S_START: begin
        target = HALF_TGT;
        if (tick) begin
          state_nx = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          if (bit_idx == BIT_LAST) begin
            state_nx = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rx_s) begin
            load_byte = 1'b1;
            state_nx  = S_IDLE;
          end else begin
            flag_err  = 1'b1;
            state_nx  = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Shift register assembles LSB-first; strobes are registered one cycle after the stop sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      shreg     <= '0;
      bit_idx   <= '0;
    end else begin
      valid     <= load_byte;
      frame_err <= flag_err;
      if (load_byte) begin
        data_out <= shreg;
      end
      if (state == S_START && tick) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Testbench for uart_rx_frame with BIT_CNT=16: serialises 8N1 frames onto rx
// and compares the observed strobes against the expected frame outcomes.
module tb_uart_rx_frame;

  localparam int BIT = 16;
  localparam int LAT = 3 + BIT / 2 + 9 * BIT;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       valid, frame_err, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] vdata[$];
  int         vcyc[$];
  int         ecyc[$];
  int         both_cnt   = 0;
  int         consec_cnt = 0;
  logic       prev_strobe = 1'b0;

  uart_rx_frame #(.BIT_CNT(BIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (valid) begin
      vdata.push_back(data_out);
      vcyc.push_back(cyc);
    end
    if (frame_err) ecyc.push_back(cyc);
    if (valid && frame_err) both_cnt++;
    if ((valid || frame_err) && prev_strobe) consec_cnt++;
    prev_strobe = valid || frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic logic [31:0] vd(input int i);
    return (i < vdata.size()) ? {24'h0, vdata[i]} : 32'hDEAD_0000 + i;
  endfunction

  function automatic int vc(input int i);
    return (i < vcyc.size()) ? vcyc[i] : -100000;
  endfunction

  task automatic clear_mon();
    vdata.delete();
    vcyc.delete();
    ecyc.delete();
  endtask

  task automatic hold(input logic v, input int cycles);
    rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  // Serialise one frame: start, 8 data bits LSB first, stop bit as given.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
    hold(stop, BIT);
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] last_good;
  logic [7:0] btb[4];
  int         t0;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data_out", {24'h0, data_out}, 32'h00);
    chk("reset_valid", {31'h0, valid}, 32'h0);
    chk("reset_frame_err", {31'h0, frame_err}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    hold(1'b1, 2 * BIT);

    // Single frame 0x55
    clear_mon();
    t0 = cyc;
    send_byte(8'h55, 1'b1);
    hold(1'b1, 2 * BIT);
    chk("single_count", vdata.size(), 1);
    chk("single_data", vd(0), 32'h55);
    chk_rng("single_latency", vc(0) - t0, LAT - 1, LAT + 1);
    chk("single_no_err", ecyc.size(), 0);
    chk("single_busy_after", {31'h0, busy}, 32'h0);
    last_good = 8'h55;

    // Back-to-back frames, zero idle gap
    btb = '{8'hA3, 8'h0F, 8'hFF, 8'h00};
    clear_mon();
    for (int i = 0; i < 4; i++) send_byte(btb[i], 1'b1);
    hold(1'b1, 2 * BIT);
    chk("b2b_count", vdata.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("b2b_data%0d", i), vd(i), {24'h0, btb[i]});
    for (int i = 1; i < 4; i++)
      chk_rng($sformatf("b2b_spacing%0d", i), vc(i) - vc(i - 1), 10 * BIT - 1, 10 * BIT + 1);
    chk("b2b_no_err", ecyc.size(), 0);
    last_good = 8'h00;

    // Short glitch rejected in START
    clear_mon();
    t0 = cyc;
    hold(1'b0, 5);
    chk("glitch_busy_high", {31'h0, busy}, 32'h1);
    rx = 1'b1;
    repeat (12 - (cyc - t0)) @(negedge clk);
    chk("glitch_busy_low", {31'h0, busy}, 32'h0);
    hold(1'b1, 2 * BIT);
    chk("glitch_no_valid", vdata.size(), 0);
    chk("glitch_no_err", ecyc.size(), 0);

    // Stop bit low followed by a long break
    clear_mon();
    send_byte(8'h3C, 1'b0);
    hold(1'b0, 40 * BIT);
    hold(1'b1, 2 * BIT);
    chk("break_err_count", ecyc.size(), 1);
    chk("break_no_valid", vdata.size(), 0);
    chk("break_data_kept", {24'h0, data_out}, {24'h0, last_good});
    clear_mon();
    send_byte(8'h81, 1'b1);
    hold(1'b1, 2 * BIT);
    chk("after_break_count", vdata.size(), 1);
    chk("after_break_data", vd(0), 32'h81);
    last_good = 8'h81;

    // Reset in the middle of a frame
    clear_mon();
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(1'(8'hE7 >> i), BIT);
    rx  = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_data_out", {24'h0, data_out}, 32'h00);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_valid", {31'h0, valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 12 * BIT);
    chk("midrst_no_strobe", vdata.size() + ecyc.size(), 0);
    send_byte(8'hC4, 1'b1);
    hold(1'b1, 2 * BIT);
    chk("midrst_next_count", vdata.size(), 1);
    chk("midrst_next_data", vd(0), 32'hC4);

    // Line held low across reset release
    rx  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_mon();
    hold(1'b0, 3 * BIT);
    hold(1'b1, 2 * BIT);
    send_byte(8'h5A, 1'b1);
    hold(1'b1, 2 * BIT);
    chk("lowrst_count", vdata.size(), 1);
    chk("lowrst_data", vd(0), 32'h5A);
    chk("lowrst_no_err", ecyc.size(), 0);

    // Random frames with random idle gaps against the frame-level model
    clear_mon();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_q.push_back(b);
      send_byte(b, 1'b1);
      hold(1'b1, $urandom_range(0, 2 * BIT));
    end
    hold(1'b1, 2 * BIT);
    chk("rand_count", vdata.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("rand_data%0d", i), vd(i), {24'h0, exp_q[i]});
    chk("rand_no_err", ecyc.size(), 0);

    chk("strobes_exclusive", both_cnt, 0);
    chk("strobes_not_consecutive", consec_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
